axi_mem_target: RTL and testbench

AXI_MEM_TARGET -- requirements
Module: axi_mem_target

---
 rtl/axi_mem_target_pkg.sv | 25 ++
 rtl/axi_mem_target_if.sv | 62 ++++++
 rtl/mem_1r1w.sv | 31 +++
 rtl/axi_mem_target.sv | 173 +++++++++++++++++
 tb/tb_axi_mem_target.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_mem_target_pkg.sv
// Shared definitions for the AXI memory target: response codes, FSM states, beat counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_mem_target_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  // Nine bits so a 256-beat burst can count to 256 without wrapping.
  localparam int BEAT_W = 9;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

endpackage

// File: rtl/axi_mem_target_if.sv
// AXI-style bus bundle (AW, W, B, AR, R channels) between a master and the memory target.
// Latency: n/a (wires only).
// Backpressure: every channel uses a valid/ready pair.
// Ports: modport slave is the target side, modport master is the initiator side.
interface axi_mem_target_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) ();

  logic                       aw_valid;
  logic                       aw_ready;
  logic [ADDR_W-1:0]          aw_addr;
  logic [7:0]                 aw_len;

  logic                       w_valid;
  logic                       w_ready;
  logic [DATA_W-1:0]          w_data;
  logic [DATA_W/8-1:0]        w_strb;
  logic                       w_last;

  logic                       b_valid;
  logic                       b_ready;
  axi_mem_target_pkg::resp_t  b_resp;

  logic                       ar_valid;
  logic                       ar_ready;
  logic [ADDR_W-1:0]          ar_addr;
  logic [7:0]                 ar_len;

  logic                       r_valid;
  logic                       r_ready;
  logic [DATA_W-1:0]          r_data;
  axi_mem_target_pkg::resp_t  r_resp;
  logic                       r_last;

  modport slave (
    input  aw_valid, aw_addr, aw_len,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_resp,
    input  b_ready,
    input  ar_valid, ar_addr, ar_len,
    output ar_ready,
    output r_valid, r_data, r_resp, r_last,
    input  r_ready
  );

  modport master (
    output aw_valid, aw_addr, aw_len,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_resp,
    output b_ready,
    output ar_valid, ar_addr, ar_len,
    input  ar_ready,
    input  r_valid, r_data, r_resp, r_last,
    output r_ready
  );

endinterface

// File: rtl/mem_1r1w.sv
// DEPTH x DATA_W storage, one synchronous read port and one byte-enabled write port.
// Latency: read data valid one cycle after re; a same-cycle write to the read word returns old data.
// Backpressure: none; rdata holds its value while re is low.
// Ports: clk; we/waddr/wstrb/wdata write port; re/raddr/rdata read port.
module mem_1r1w #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W/8-1:0]      wstrb,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset: contents survive rst_n. Read-first falls out of the non-blocking update.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_mem_target.sv
// AXI INCR-burst memory target with independent write (AW/W/B) and read (AR/R) engines.
// Latency: B one cycle after final W beat; first R beat one cycle after AR, then one beat per cycle.
// Backpressure: holds B/R outputs stable while ready is low; accepts one address at a time per side.
// Ports: clk, rst_n (async active-low), bus (slave modport of axi_mem_target_if).
module axi_mem_target
  import axi_mem_target_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  axi_mem_target_if.slave bus
);

  localparam int BYTE_SH = $clog2(DATA_W/8);
  localparam int MEM_AW  = $clog2(DEPTH);
  // One extra bit so start index + 255 never wraps back into range.
  localparam int IDX_W   = ADDR_W + 1;
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} >> BYTE_SH;
  endfunction

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return idx < DEPTH_IDX;
  endfunction

  // ---------------- write engine ----------------
  w_state_t            w_state, w_state_nx;
  logic [IDX_W-1:0]    w_idx;
  logic [7:0]          w_len;
  logic [BEAT_W-1:0]   w_beat;
  logic                w_err;
  logic                w_hs;
  logic                beat_last;
  logic                beat_oor;
  logic                beat_err;
  logic                mem_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = w_state;
    w_hs       = 1'b0;
    mem_we     = 1'b0;
    beat_last  = (w_beat == BEAT_W'(w_len));
    beat_oor   = !in_range(w_idx);
    // A w_last that disagrees with our own beat count flags an error but does not end the burst.
    beat_err   = beat_oor || (bus.w_last != beat_last);
    case (w_state)
      W_IDLE: if (bus.aw_valid) w_state_nx = W_DATA;
      W_DATA: begin
        if (bus.w_valid) begin
          w_hs   = 1'b1;
          mem_we = !beat_oor;
          if (beat_last) w_state_nx = W_RESP;
        end
      end
      W_RESP: if (bus.b_ready) w_state_nx = W_IDLE;
      default: w_state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_idx  <= '0;
      w_len  <= '0;
      w_beat <= '0;
      w_err  <= 1'b0;
    end else if (w_state == W_IDLE && bus.aw_valid) begin
      w_idx  <= word_idx(bus.aw_addr);
      w_len  <= bus.aw_len;
      w_beat <= '0;
      w_err  <= 1'b0;
    end else if (w_hs) begin
      w_idx  <= w_idx + IDX_W'(1);
      w_beat <= w_beat + BEAT_W'(1);
      w_err  <= w_err | beat_err;
    end
  end

  assign bus.aw_ready = (w_state == W_IDLE);
  assign bus.w_ready  = (w_state == W_DATA);
  assign bus.b_valid  = (w_state == W_RESP);
  assign bus.b_resp   = ((w_state == W_RESP) && w_err) ? RESP_SLVERR : RESP_OKAY;

  // ---------------- read engine ----------------
  r_state_t            r_state, r_state_nx;
  logic [IDX_W-1:0]    r_idx;
  logic [7:0]          r_len;
  logic [BEAT_W-1:0]   r_beat;
  logic                r_oor;
  logic                r_last_beat;
  logic                rd_en;
  logic [IDX_W-1:0]    rd_idx;
  logic [DATA_W-1:0]   mem_rdata;

  assign r_last_beat = (r_beat == BEAT_W'(r_len));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_state_nx;
  end

  // The next word is fetched only when the current beat is taken, so a stall leaves
  // the memory output register (and hence r_data) untouched.
  always_comb begin
    r_state_nx = r_state;
    rd_en      = 1'b0;
    rd_idx     = r_idx + IDX_W'(1);
    case (r_state)
      R_IDLE: begin
        if (bus.ar_valid) begin
          rd_en      = 1'b1;
          rd_idx     = word_idx(bus.ar_addr);
          r_state_nx = R_DATA;
        end
      end
      R_DATA: begin
        if (bus.r_ready) begin
          if (r_last_beat) r_state_nx = R_IDLE;
          else             rd_en      = 1'b1;
        end
      end
      default: r_state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_len  <= '0;
      r_beat <= '0;
      r_oor  <= 1'b0;
    end else if (rd_en) begin
      r_idx <= rd_idx;
      r_oor <= !in_range(rd_idx);
      if (r_state == R_IDLE) begin
        r_len  <= bus.ar_len;
        r_beat <= '0;
      end else begin
        r_beat <= r_beat + BEAT_W'(1);
      end
    end
  end

  assign bus.ar_ready = (r_state == R_IDLE);
  assign bus.r_valid  = (r_state == R_DATA);
  assign bus.r_last   = (r_state == R_DATA) && r_last_beat;
  assign bus.r_data   = ((r_state == R_DATA) && !r_oor) ? mem_rdata : '0;
  assign bus.r_resp   = ((r_state == R_DATA) && r_oor) ? RESP_SLVERR : RESP_OKAY;

  mem_1r1w #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (w_idx[MEM_AW-1:0]),
    .wstrb (bus.w_strb),
    .wdata (bus.w_data),
    .re    (rd_en),
    .raddr (rd_idx[MEM_AW-1:0]),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_axi_mem_target.sv
// Testbench for axi_mem_target: directed bursts with a scoreboard on the B and R channels.
// Latency: n/a.
// Backpressure: r_ready is forced low or randomised to exercise stalls.
module tb_axi_mem_target;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_mem_target_if #(.ADDR_W(32), .DATA_W(64)) ifc ();

  axi_mem_target #(.ADDR_W(32), .DATA_W(64), .DEPTH(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  typedef struct {
    logic [63:0] d;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;

  logic [1:0] b_q [$];
  rexp_t      r_q [$];

  int n_cmp = 0;
  int n_bad = 0;

  bit rand_mode = 1'b0;
  bit rdy_force = 1'b1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // r_ready driver, the only process that writes it.
  initial begin
    ifc.r_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ifc.r_ready = rand_mode ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // Monitor: pops expectations on every handshake and checks hold-stability on R stalls.
  initial begin
    bit          stalled = 1'b0;
    logic [66:0] held = '0;
    rexp_t       e;
    logic [1:0]  eb;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) check("r_stable", {ifc.r_valid, ifc.r_data, ifc.r_resp, ifc.r_last}, {1'b1, held});
        if (ifc.r_valid && ifc.r_ready) begin
          stalled = 1'b0;
          if (r_q.size() == 0) begin
            timeout("r_unexpected_beat");
          end else begin
            e = r_q.pop_front();
            check("r_beat", {ifc.r_data, ifc.r_resp, ifc.r_last}, {e.d, e.resp, e.last});
          end
        end else if (ifc.r_valid) begin
          stalled = 1'b1;
          held    = {ifc.r_data, ifc.r_resp, ifc.r_last};
        end else begin
          stalled = 1'b0;
        end
        if (ifc.b_valid && ifc.b_ready) begin
          if (b_q.size() == 0) begin
            timeout("b_unexpected");
          end else begin
            eb = b_q.pop_front();
            check("b_resp", ifc.b_resp, eb);
          end
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while ((b_q.size() != 0 || r_q.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      timeout(name);
      b_q.delete();
      r_q.delete();
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [63:0] base,
                          input logic [7:0] strb, input int last_pos, input logic [1:0] exp_resp);
    int n;
    b_q.push_back(exp_resp);
    ifc.aw_valid = 1'b1;
    ifc.aw_addr  = addr;
    ifc.aw_len   = len;
    n = 0;
    while (!ifc.aw_ready && n < 100) begin tick(); n++; end
    if (n >= 100) timeout("aw_ready");
    tick();
    ifc.aw_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      ifc.w_valid = 1'b1;
      ifc.w_data  = base + 64'(i);
      ifc.w_strb  = strb;
      ifc.w_last  = (i == last_pos);
      n = 0;
      while (!ifc.w_ready && n < 100) begin tick(); n++; end
      if (n >= 100) timeout("w_ready");
      tick();
    end
    ifc.w_valid = 1'b0;
    ifc.w_last  = 1'b0;
    wait_drain("b_drain");
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    ifc.ar_valid = 1'b1;
    ifc.ar_addr  = addr;
    ifc.ar_len   = len;
    while (!ifc.ar_ready && n < 100) begin tick(); n++; end
    if (n >= 100) timeout("ar_ready");
    tick();
    ifc.ar_valid = 1'b0;
    wait_drain("r_drain");
  endtask

  task automatic push_r(input logic [63:0] d, input logic [1:0] resp, input logic last);
    rexp_t e;
    e.d = d; e.resp = resp; e.last = last;
    r_q.push_back(e);
  endtask

  task automatic check_reset_outputs();
    check("rst_aw_ready", ifc.aw_ready, 1'b1);
    check("rst_ar_ready", ifc.ar_ready, 1'b1);
    check("rst_w_ready",  ifc.w_ready,  1'b0);
    check("rst_b_valid",  ifc.b_valid,  1'b0);
    check("rst_r_valid",  ifc.r_valid,  1'b0);
    check("rst_r_last",   ifc.r_last,   1'b0);
    check("rst_b_resp",   ifc.b_resp,   2'b00);
    check("rst_r_resp",   ifc.r_resp,   2'b00);
    check("rst_r_data",   ifc.r_data,   64'h0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.aw_valid = 1'b0; ifc.aw_addr = '0; ifc.aw_len = '0;
    ifc.w_valid  = 1'b0; ifc.w_data  = '0; ifc.w_strb = '0; ifc.w_last = 1'b0;
    ifc.b_ready  = 1'b1;
    ifc.ar_valid = 1'b0; ifc.ar_addr = '0; ifc.ar_len = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    tick();

    // Four-beat burst at 0x10 (words 2..5), then read it back.
    do_write(32'h10, 8'd3, 64'd1, 8'hFF, 3, 2'b00);
    for (int i = 0; i < 4; i++) push_r(64'(i + 1), 2'b00, i == 3);
    do_read(32'h10, 8'd3);

    // Byte strobes: clear word 10, low half all-ones, then high half 0x11.
    do_write(32'h50, 8'd0, 64'h0, 8'hFF, 0, 2'b00);
    do_write(32'h50, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0, 2'b00);
    push_r(64'h0000_0000_FFFF_FFFF, 2'b00, 1'b1);
    do_read(32'h50, 8'd0);
    do_write(32'h50, 8'd0, 64'h1111_1111_1111_1111, 8'hF0, 0, 2'b00);
    push_r(64'h1111_1111_FFFF_FFFF, 2'b00, 1'b1);
    do_read(32'h50, 8'd0);

    // Burst straddling the top of memory: second beat lands at word 256.
    do_write(32'h7F8, 8'd1, 64'hA5, 8'hFF, 1, 2'b10);
    push_r(64'hA5, 2'b00, 1'b0);
    push_r(64'h0,  2'b10, 1'b1);
    do_read(32'h7F8, 8'd1);

    // Early w_last on beat 2 of 4: all beats still written, response SLVERR.
    do_write(32'h100, 8'd3, 64'h100, 8'hFF, 1, 2'b10);
    for (int i = 0; i < 4; i++) push_r(64'h100 + 64'(i), 2'b00, i == 3);
    do_read(32'h100, 8'd3);

    // Full 256-beat burst, read back with random r_ready.
    do_write(32'h0, 8'd255, 64'h1000, 8'hFF, 255, 2'b00);
    for (int i = 0; i < 256; i++) push_r(64'h1000 + 64'(i), 2'b00, i == 255);
    rand_mode = 1'b1;
    do_read(32'h0, 8'd255);
    rand_mode = 1'b0;

    // Reset in the middle of a stalled read and a half-done write.
    rdy_force = 1'b0;
    tick();
    tick();
    ifc.ar_valid = 1'b1; ifc.ar_addr = 32'h0; ifc.ar_len = 8'd3;
    tick();
    ifc.ar_valid = 1'b0;
    ifc.aw_valid = 1'b1; ifc.aw_addr = 32'h200; ifc.aw_len = 8'd3;
    tick();
    ifc.aw_valid = 1'b0;
    check("mid_w_ready", ifc.w_ready, 1'b1);
    for (int i = 0; i < 2; i++) begin
      ifc.w_valid = 1'b1; ifc.w_data = 64'hDEAD + 64'(i); ifc.w_strb = 8'hFF; ifc.w_last = 1'b0;
      tick();
    end
    ifc.w_valid = 1'b0;
    check("mid_r_valid", ifc.r_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    tick();
    tick();
    rst_n = 1'b1;
    rdy_force = 1'b1;
    tick();
    tick();
    do_write(32'h200, 8'd3, 64'h50, 8'hFF, 3, 2'b00);
    for (int i = 0; i < 4; i++) push_r(64'h50 + 64'(i), 2'b00, i == 3);
    do_read(32'h200, 8'd3);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
